// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the iterative divider.
// Special-case precedence for packing a quotient lives here.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fdiv_state_t;

    localparam int BIAS   = 127;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    localparam logic [30:0] FP_ZERO = 31'b0;
    localparam logic [30:0] FP_INF  = {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};

    function automatic logic [31:0] pack_result(
        input logic              s,
        input logic              z1,
        input logic              z2,
        input logic signed [9:0] e,
        input logic [22:0]       frac
    );
        logic [31:0] r;
        if (z1)
            r = {s, FP_ZERO};
        else if (z2)
            r = {s, FP_INF};
        else if (e <= 10'sd0)
            r = {s, FP_ZERO};
        else if (e >= 10'sd255)
            r = {s, FP_INF};
        else
            r = {s, e[7:0], frac};
        return r;
    endfunction

endpackage

// File: rtl/fdiv_step.sv
// One restoring division step: doubles the partial remainder
// (except on the first step) and subtracts the divisor if it fits.
import fpu_pkg::*;

module fdiv_step (
    input  logic [24:0] rem,
    input  logic [23:0] m2,
    input  logic        shift,
    output logic [24:0] rem_nxt,
    output logic        qbit
);

    logic [25:0] dvd;
    logic [24:0] diff;

    // first step compares m1 to m2 directly so q has 2^25 scaling
    assign dvd     = shift ? {rem, 1'b0} : {1'b0, rem};
    assign qbit    = dvd >= {2'b0, m2};
    assign diff    = dvd[24:0] - {1'b0, m2};
    assign rem_nxt = qbit ? diff : dvd[24:0];

endmodule

// File: rtl/fdiv.sv
// Iterative single-precision divider, y = x1 / x2, one
// quotient bit per cycle, flush-to-zero, round-half-up.
import fpu_pkg::*;

module fdiv #(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] y
);

    fdiv_state_t state, state_nxt;

    logic [4:0]  count;
    logic        s;
    logic [7:0]  e1, e2;
    logic [23:0] m2;
    logic [24:0] rem, rem_nxt;
    logic [25:0] q;
    logic        qbit;

    logic [22:0]       frac_raw;
    logic              rbit;
    logic signed [9:0] e_raw, e_adj;
    logic [23:0]       fr_sum;
    logic [31:0]       y_nxt;

    fdiv_step u_step (
        .rem     (rem),
        .m2      (m2),
        .shift   (count != 5'd0),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (ready) state_nxt = DIV;
            DIV:  if (count == 5'(QBITS - 1)) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if (q[25]) begin
            frac_raw = q[24:2];
            rbit     = q[1];
            e_raw    = $signed({2'b0, e1}) - $signed({2'b0, e2})
                     + 10'(BIAS);
        end else begin
            frac_raw = q[23:1];
            rbit     = q[0];
            e_raw    = $signed({2'b0, e1}) - $signed({2'b0, e2})
                     + 10'(BIAS - 1);
        end
        fr_sum = {1'b0, frac_raw} + {23'b0, rbit};
        // a carry leaves frac at zero and bumps the exponent
        e_adj  = e_raw + (fr_sum[23] ? 10'sd1 : 10'sd0);
        y_nxt  = pack_result(s, e1 == 8'd0, e2 == 8'd0,
                             e_adj, fr_sum[22:0]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            valid <= 1'b0;
            y     <= 32'b0;
            count <= 5'd0;
            s     <= 1'b0;
            e1    <= 8'd0;
            e2    <= 8'd0;
            m2    <= 24'd0;
            rem   <= 25'd0;
            q     <= 26'd0;
        end else begin
            state <= state_nxt;
            valid <= (state == DONE);
            unique case (state)
                IDLE: if (ready) begin
                    s     <= x1[31] ^ x2[31];
                    e1    <= x1[30:23];
                    e2    <= x2[30:23];
                    m2    <= {1'b1, x2[22:0]};
                    rem   <= {2'b01, x1[22:0]};
                    q     <= 26'd0;
                    count <= 5'd0;
                end
                DIV: begin
                    rem   <= rem_nxt;
                    q     <= {q[24:0], qbit};
                    count <= count + 5'd1;
                end
                NORM: y <= y_nxt;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv.sv
// Self-checking bench for fdiv: directed vectors, control
// scenarios and random operands against an arithmetic model.
module tb_fdiv;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] x1, x2;
    logic        ready;
    logic        valid;
    logic [31:0] y;

    int checks = 0;
    int errors = 0;

    localparam int LAT = 28;

    fdiv #(.QBITS(26)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .x1    (x1),
        .x2    (x2),
        .ready (ready),
        .valid (valid),
        .y     (y)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b);
        logic   s;
        int     e1, e2, e;
        longint m1, m2, q, frac, rb;
        s  = a[31] ^ b[31];
        e1 = int'(a[30:23]);
        e2 = int'(b[30:23]);
        if (e1 == 0) return {s, 31'b0};
        if (e2 == 0) return {s, 8'hFF, 23'b0};
        m1 = longint'({1'b1, a[22:0]});
        m2 = longint'({1'b1, b[22:0]});
        q  = (m1 * (64'sd1 << 25)) / m2;
        if (q >= (64'sd1 << 25)) begin
            frac = (q >> 2) % (64'sd1 << 23);
            rb   = (q >> 1) % 2;
            e    = e1 - e2 + 127;
        end else begin
            frac = (q >> 1) % (64'sd1 << 23);
            rb   = q % 2;
            e    = e1 - e2 + 126;
        end
        frac = frac + rb;
        if (frac == (64'sd1 << 23)) begin
            frac = 0;
            e    = e + 1;
        end
        if (e <= 0)   return {s, 31'b0};
        if (e >= 255) return {s, 8'hFF, 23'b0};
        return {s, 8'(e), 23'(frac)};
    endfunction

    // start one op, wait for valid, check latency and pulse width
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res);
        int k;
        bit found;
        @(negedge clk);
        x1 = a; x2 = b; ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        k = 0; found = 0;
        while (k < 40 && !found) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (valid) found = 1;
        end
        res = y;
        checks++;
        if (!found || k != LAT) begin
            errors++;
            $display("FAIL latency a=%h b=%h got=%0d exp=%0d",
                     a, b, found ? k : -1, LAT);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width got=%b exp=0", valid);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; ready = 1'b0; x1 = '0; x2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || y !== 32'h0) begin
            errors++;
            $display("FAIL reset valid=%b y=%h exp 0/0", valid, y);
        end
        rstn = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [31:0] ve [10];
        logic [31:0] r;
        va = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
               32'h00000000, 32'h80000000, 32'h00000000, 32'h00800000,
               32'h7F000000, 32'h40490FDB};
        vb = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000,
               32'h40A00000, 32'h40A00000, 32'h00000000, 32'h40000000,
               32'h3F000000, 32'hC0000000};
        ve = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'hFF800000,
               32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000,
               32'h7F800000, ref_div(32'h40490FDB, 32'hC0000000)};
        for (int i = 0; i < 10; i++) begin
            do_op(va[i], vb[i], r);
            checks++;
            if (r !== ve[i]) begin
                errors++;
                $display("FAIL directed%0d %h/%h got=%h exp=%h",
                         i, va[i], vb[i], r, ve[i]);
            end
        end
    endtask

    task automatic test_ignore_ready();
        int k;
        bit seen;
        @(negedge clk);
        x1 = 32'h40C00000; x2 = 32'h40000000; ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        x1 = 32'h3F800000; x2 = 32'h40400000; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        k = 11; seen = 0;
        while (k < 40 && !seen) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (valid) seen = 1;
        end
        checks++;
        if (!seen || k != LAT || y !== 32'h40400000) begin
            errors++;
            $display("FAIL ignore_ready y=%h lat=%0d exp=40400000/%0d",
                     y, k, LAT);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL ignore_ready_extra got=valid exp=none");
        end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        bit seen;
        @(negedge clk);
        x1 = 32'h3F800000; x2 = 32'h40400000; ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        checks++;
        if (seen || y !== 32'h0) begin
            errors++;
            $display("FAIL abort valid_seen=%0d y=%h exp 0/0", seen, y);
        end
        do_op(32'h40C00000, 32'h40000000, r);
        checks++;
        if (r !== 32'h40400000) begin
            errors++;
            $display("FAIL after_abort got=%h exp=40400000", r);
        end
    endtask

    task automatic test_back_to_back();
        int hits[$];
        @(negedge clk);
        x1 = 32'h40C00000; x2 = 32'h40000000; ready = 1'b1;
        for (int i = 0; i < 130; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) hits.push_back(i);
            if (i == 99) ready = 1'b0;
        end
        checks++;
        if (hits.size() != 4 || hits[0] != LAT) begin
            errors++;
            $display("FAIL b2b_count got=%0d first=%0d exp=4/%0d",
                     hits.size(), hits.size() ? hits[0] : -1, LAT);
        end
        for (int i = 1; i < hits.size(); i++) begin
            checks++;
            if (hits[i] - hits[i-1] != 29) begin
                errors++;
                $display("FAIL b2b_gap%0d got=%0d exp=29",
                         i, hits[i] - hits[i-1]);
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] a, b, r, e;
        for (int i = 0; i < n; i++) begin
            a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            if (i % 4 == 0)
                b[30:23] = 8'($urandom_range(110, 144));
            if (i % 4 == 0)
                a[30:23] = 8'($urandom_range(110, 144));
            e = ref_div(a, b);
            do_op(a, b, r);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL random%0d %h/%h got=%h exp=%h",
                         i, a, b, r, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_ready();
        test_abort();
        test_back_to_back();
        test_random(2000);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
